sa_attn_core: RTL and testbench

Parametrised single-head self-attention engine, successor to the fixed 8×8 SA block. It loads a T×D token matrix and three D×D weight matrices (Q, K, V) serially, then computes P = ReLU((X·Wq)(X·Wk)ᵀ / SCALE_DIV)·(X·Wv) with one time-shared signed MAC. It streams the T·D results out row-major under a valid/ready handshake. It sits between the token buffer and the downstream layer-norm stage.

---
 rtl/sa_attn_pkg.sv | 30 +++
 rtl/sa_mac.sv | 39 +++
 rtl/sa_attn_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sa_attn_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_attn_pkg.sv
// Shared types and sizing helpers for the single-head self-attention engine.
// Default dimensions live here so the core and its MAC agree on them.
package sa_attn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PROJ,
        S_SCORE,
        S_CTX,
        S_OUT
    } sa_state_e;

    localparam int SA_D         = 8;
    localparam int SA_TMAX      = 8;
    localparam int SA_DW        = 8;
    localparam int SA_OW        = 64;
    localparam int SA_SCALE_DIV = 3;

    // Width of the load beat counter covering all 3*D*D weight beats.
    function automatic int beat_cnt_w(input int d);
        return $clog2(3 * d * d);
    endfunction

    // Loop index width: wide enough for D-1 and TMAX-1 plus one spare bit.
    function automatic int idx_w(input int d, input int tmax);
        return ((d > tmax) ? $clog2(d) : $clog2(tmax)) + 1;
    endfunction

endpackage

// File: rtl/sa_mac.sv
// Signed multiply-accumulate shared by the projection, score and context phases.
// sum is the value the accumulator takes on this edge, so callers can store it directly.
module sa_mac
    import sa_attn_pkg::*;
#(
    parameter int OW = SA_OW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [OW-1:0] a,
    input  logic signed [OW-1:0] b,
    output logic signed [OW-1:0] sum
);

    logic signed [OW-1:0] acc_q;
    logic signed [OW-1:0] acc_d;
    logic signed [OW-1:0] prod;

    assign prod = a * b;
    assign sum  = (clr ? '0 : acc_q) + prod;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sa_attn_core.sv
// Self-attention engine: serial load, Q/K/V projection, ReLU-scaled scores, context
// product on one shared MAC, then row-major streaming of the T*D result matrix.
module sa_attn_core
    import sa_attn_pkg::*;
#(
    parameter int D         = SA_D,
    parameter int TMAX      = SA_TMAX,
    parameter int DW        = SA_DW,
    parameter int OW        = SA_OW,
    parameter int SCALE_DIV = SA_SCALE_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cg_en,
    input  logic                      in_valid,
    input  logic [$clog2(TMAX):0]     T,
    input  logic signed [DW-1:0]      in_data,
    input  logic signed [DW-1:0]      w_Q,
    input  logic signed [DW-1:0]      w_K,
    input  logic signed [DW-1:0]      w_V,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OW-1:0]      out_data,
    output logic                      busy
);

    localparam int TW    = $clog2(TMAX) + 1;
    localparam int NBEAT = 3 * D * D;
    localparam int LW    = beat_cnt_w(D);
    localparam int IW    = idx_w(D, TMAX);
    localparam int XN    = TMAX * D;
    localparam int WN    = D * D;
    localparam int SN    = TMAX * TMAX;
    localparam int XA    = $clog2(XN);
    localparam int WA    = $clog2(WN);
    localparam int SAW   = $clog2(SN);
    localparam int OIW   = $clog2(XN + 1);

    localparam logic [TW-1:0]        TMAX_T    = TW'(TMAX);
    localparam logic [IW-1:0]        D_M1      = IW'(D - 1);
    localparam logic [LW-1:0]        LAST_BEAT = LW'(NBEAT - 1);
    localparam logic signed [OW-1:0] DIV_C     = OW'(SCALE_DIV);

    sa_state_e state_q, state_d, next_phase;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  t_q, t_d, t_in_eff;
    logic [1:0]     mat_q, mat_d;
    logic [IW-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [OIW-1:0] oidx_q, oidx_d;
    logic           out_valid_q, out_valid_d;
    logic signed [OW-1:0] out_data_q, out_data_d;

    logic signed [DW-1:0] x_mem  [XN];
    logic signed [DW-1:0] wq_mem [WN];
    logic signed [DW-1:0] wk_mem [WN];
    logic signed [DW-1:0] wv_mem [WN];
    logic signed [OW-1:0] q_mem  [XN];
    logic signed [OW-1:0] k_mem  [XN];
    logic signed [OW-1:0] v_mem  [XN];
    logic signed [OW-1:0] s_mem  [SN];
    logic signed [OW-1:0] p_mem  [XN];

    logic [IW-1:0]  t_m1, k_last, j_last;
    logic [1:0]     m_last;
    logic           k_end, j_end, i_end, m_end, computing, ld_we;
    logic [XA-1:0]  x_ra, kk_ra, v_ra, e_wa, o_ra, ld_xa;
    logic [WA-1:0]  w_ra, ld_wa;
    logic [SAW-1:0] s_ra, s_wa;
    logic [OIW-1:0] td;
    int             ld_n;
    logic signed [DW-1:0] x_op, w_sel;
    logic signed [OW-1:0] mac_a, mac_b, mac_sum, score_q, score_s;

    // T=0 runs as a single token; oversize T clamps to the buffer depth.
    assign t_in_eff = (T == '0) ? TW'(1) : ((T > TMAX_T) ? TMAX_T : T);

    assign computing = (state_q == S_PROJ) || (state_q == S_SCORE) || (state_q == S_CTX);
    assign t_m1   = IW'(t_q) - IW'(1);
    assign k_last = (state_q == S_CTX) ? t_m1 : D_M1;
    assign j_last = (state_q == S_SCORE) ? t_m1 : D_M1;
    assign m_last = (state_q == S_PROJ) ? 2'd2 : 2'd0;
    assign k_end  = (k_q == k_last);
    assign j_end  = (j_q == j_last);
    assign i_end  = (i_q == t_m1);
    assign m_end  = (mat_q == m_last);

    assign x_ra  = XA'(int'(i_q) * D + int'(k_q));
    assign w_ra  = WA'(int'(k_q) * D + int'(j_q));
    assign kk_ra = XA'(int'(j_q) * D + int'(k_q));
    assign s_ra  = SAW'(int'(i_q) * TMAX + int'(k_q));
    assign v_ra  = XA'(int'(k_q) * D + int'(j_q));
    assign e_wa  = XA'(int'(i_q) * D + int'(j_q));
    assign s_wa  = SAW'(int'(i_q) * TMAX + int'(j_q));
    assign o_ra  = XA'(oidx_q);
    assign td    = OIW'(int'(t_q) * D);

    // With cg_en low the buffers capture every cycle at the pending beat slot;
    // the valid beat always overwrites that slot, so results do not change.
    assign ld_we = ((state_q == S_IDLE) || (state_q == S_LOAD)) && (in_valid || !cg_en);
    assign ld_n  = int'(cnt_q);
    assign ld_xa = XA'(ld_n);
    assign ld_wa = WA'((ld_n >= 2 * WN) ? ld_n - 2 * WN : ((ld_n >= WN) ? ld_n - WN : ld_n));

    always_comb begin
        x_op  = x_mem[x_ra];
        w_sel = wq_mem[w_ra];
        mac_a = '0;
        mac_b = '0;
        case (mat_q)
            2'd1:    w_sel = wk_mem[w_ra];
            2'd2:    w_sel = wv_mem[w_ra];
            default: ;
        endcase
        case (state_q)
            S_PROJ: begin
                mac_a = {{(OW - DW){x_op[DW-1]}}, x_op};
                mac_b = {{(OW - DW){w_sel[DW-1]}}, w_sel};
            end
            S_SCORE: begin
                mac_a = q_mem[x_ra];
                mac_b = k_mem[kk_ra];
            end
            S_CTX: begin
                mac_a = s_mem[s_ra];
                mac_b = v_mem[v_ra];
            end
            default: ;
        endcase
    end

    sa_mac #(.OW(OW)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (k_q == '0),
        .en  (computing),
        .a   (mac_a),
        .b   (mac_b),
        .sum (mac_sum)
    );

    assign score_q = mac_sum / DIV_C;
    assign score_s = score_q[OW-1] ? '0 : score_q;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            if (ld_n < XN) begin
                x_mem[ld_xa] <= in_data;
            end
            if (ld_n < WN) begin
                wq_mem[ld_wa] <= w_Q;
            end else if (ld_n < 2 * WN) begin
                wk_mem[ld_wa] <= w_K;
            end else begin
                wv_mem[ld_wa] <= w_V;
            end
        end
        if (computing && k_end) begin
            case (state_q)
                S_PROJ: begin
                    case (mat_q)
                        2'd0:    q_mem[e_wa] <= mac_sum;
                        2'd1:    k_mem[e_wa] <= mac_sum;
                        default: v_mem[e_wa] <= mac_sum;
                    endcase
                end
                S_SCORE: s_mem[s_wa] <= score_s;
                default: p_mem[e_wa] <= mac_sum;
            endcase
        end
    end

    always_comb begin
        next_phase = S_OUT;
        if (state_q == S_PROJ) begin
            next_phase = S_SCORE;
        end else if (state_q == S_SCORE) begin
            next_phase = S_CTX;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        t_d         = t_q;
        mat_d       = mat_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        oidx_d      = oidx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_LOAD;
                    cnt_d   = LW'(1);
                    t_d     = t_in_eff;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_PROJ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            S_PROJ, S_SCORE, S_CTX: begin
                // Nested k -> j -> i -> matrix loop; one MAC per cycle.
                if (!k_end) begin
                    k_d = k_q + IW'(1);
                end else begin
                    k_d = '0;
                    if (!j_end) begin
                        j_d = j_q + IW'(1);
                    end else begin
                        j_d = '0;
                        if (!i_end) begin
                            i_d = i_q + IW'(1);
                        end else begin
                            i_d = '0;
                            if (!m_end) begin
                                mat_d = mat_q + 2'd1;
                            end else begin
                                mat_d   = '0;
                                state_d = next_phase;
                            end
                        end
                    end
                end
            end
            S_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = p_mem[o_ra];
                    oidx_d      = oidx_q + OIW'(1);
                end else if (out_ready) begin
                    if (oidx_q == td) begin
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        oidx_d      = '0;
                        state_d     = S_IDLE;
                    end else begin
                        out_data_d = p_mem[o_ra];
                        oidx_d     = oidx_q + OIW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            mat_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            oidx_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
            mat_q       <= mat_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            oidx_q      <= oidx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sa_attn_core.sv
// Directed bench for sa_attn_core: identity, clipped score, width extreme, backpressure,
// T clamping with load gaps, and reset during the score phase.
module tb_sa_attn_core;

    logic              clk = 1'b0;
    logic              rst;
    logic              cg_en;
    logic              in_valid;
    logic [3:0]        t_in;
    logic signed [7:0] in_data;
    logic signed [7:0] w_q;
    logic signed [7:0] w_k;
    logic signed [7:0] w_v;
    logic              out_valid;
    logic              out_ready;
    logic signed [63:0] out_data;
    logic              busy;

    int passes = 0;
    int fails  = 0;
    int checks = 0;
    logic [63:0] exp_vals [64];

    always #5 clk = ~clk;

    sa_attn_core dut (
        .clk       (clk),
        .rst       (rst),
        .cg_en     (cg_en),
        .in_valid  (in_valid),
        .T         (t_in),
        .in_data   (in_data),
        .w_Q       (w_q),
        .w_K       (w_k),
        .w_V       (w_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    function automatic logic [7:0] xval(input int m, input int r);
        if (m == 0) return 8'h01;
        if (m == 1) return 8'(r + 1);
        return 8'h80;
    endfunction

    function automatic logic [7:0] wval(input int m, input int r, input int c);
        if (m == 0) return (r == c) ? 8'h01 : 8'h00;
        if (m == 1) return (r == c) ? 8'hFF : 8'h00;
        return 8'h80;
    endfunction

    task automatic send_frame(input int tf, input int xm, input int mq, input int mk,
                              input int mv, input bit gaps);
        logic [3:0] tf4;
        tf4 = 4'(tf);
        for (int b = 0; b < 192; b++) begin
            if (gaps && (b % 37 == 5)) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                w_q      = 8'h5A;
                w_k      = 8'h5A;
                w_v      = 8'h5A;
                t_in     = 4'd7;
                repeat (3) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            t_in     = (b == 0) ? tf4 : 4'd5;
            in_data  = (b < 64) ? xval(xm, b / 8) : 8'h7F;
            w_q      = (b < 64) ? wval(mq, b / 8, b % 8) : 8'h11;
            w_k      = (b >= 64 && b < 128) ? wval(mk, (b - 64) / 8, (b - 64) % 8) : 8'h22;
            w_v      = (b >= 128) ? wval(mv, (b - 128) / 8, (b - 128) % 8) : 8'h33;
            @(posedge clk); #1;
            if (b == 0) check("busy_rise", 64'(busy), 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lat, input bit noise);
        int n = 0;
        int zbad = 0;
        while (!out_valid && n < lat + 50) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                t_in     = 4'($urandom);
            end
            if (out_data !== 64'd0) zbad++;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_idle_data_zero"}, 64'(zbad), 64'd0);
    endtask

    task automatic recv(input string tag, input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        int stall_bad = 0;
        int zero_bad = 0;
        logic prev_stall = 1'b0;
        logic [63:0] prev_d = '0;
        while (got < n && cyc < 4000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (prev_stall && out_data !== prev_d) stall_bad++;
                if (out_ready) begin
                    check($sformatf("%s[%0d]", tag, got), out_data, exp_vals[got]);
                    got++;
                end
                prev_stall = !out_ready;
                prev_d     = out_data;
            end else begin
                if (out_data !== 64'd0) zero_bad++;
                prev_stall = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(n));
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        check({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
        if (rnd) begin
            check({tag, "_stall_stable"}, 64'(stall_bad), 64'd0);
            check({tag, "_invalid_zero"}, 64'(zero_bad), 64'd0);
        end else begin
            check({tag, "_no_bubbles"}, 64'(cyc), 64'(n));
        end
    endtask

    task automatic fill_exp(input int n, input logic [63:0] v);
        for (int e = 0; e < n; e++) exp_vals[e] = v;
    endtask

    initial begin
        logic [63:0] row_p [4];
        rst       = 1'b1;
        cg_en     = 1'b1;
        in_valid  = 1'b0;
        t_in      = 4'd0;
        in_data   = 8'h00;
        w_q       = 8'h00;
        w_k       = 8'h00;
        w_v       = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity, positive score: A=8, S=2, every result 2.
        out_ready = 1'b1;
        send_frame(1, 0, 0, 0, 0, 1'b0);
        wait_valid("ident", 209, 1'b0);
        fill_exp(8, 64'd2);
        recv("ident", 8, 1'b0);

        // Negative score clipped to zero; buffers captured with gating disabled.
        cg_en = 1'b0;
        send_frame(1, 0, 0, 1, 0, 1'b0);
        wait_valid("neg", 209, 1'b1);
        fill_exp(8, 64'd0);
        recv("neg", 8, 1'b0);
        cg_en = 1'b1;

        // Width extreme: Q=K=V=2^17, A=2^37, S=45812984490, P=S*2^20.
        send_frame(8, 2, 2, 2, 2, 1'b0);
        wait_valid("wide", 2561, 1'b1);
        fill_exp(64, 64'd48038396024586240);
        recv("wide", 64, 1'b0);

        // Backpressure: X row i = i+1, identity weights, T=4.
        row_p[0] = 64'd76;
        row_p[1] = 64'd157;
        row_p[2] = 64'd240;
        row_p[3] = 64'd316;
        send_frame(4, 1, 0, 0, 0, 1'b0);
        wait_valid("bp", 1025, 1'b0);
        for (int e = 0; e < 32; e++) exp_vals[e] = row_p[e / 8];
        recv("bp", 32, 1'b1);

        // T=0 runs as T=1, with gaps in the load stream.
        cg_en = 1'b0;
        send_frame(0, 0, 0, 0, 0, 1'b1);
        wait_valid("t0gap", 209, 1'b0);
        fill_exp(8, 64'd2);
        recv("t0gap", 8, 1'b0);
        cg_en = 1'b1;

        // T=15 clamps to 8.
        send_frame(15, 2, 2, 2, 2, 1'b1);
        wait_valid("t15", 2561, 1'b0);
        fill_exp(64, 64'd48038396024586240);
        recv("t15", 64, 1'b0);

        // Reset asserted during SCORE, then a clean identity frame.
        send_frame(1, 0, 0, 0, 0, 1'b0);
        repeat (196) begin @(posedge clk); #1; end
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(1, 0, 0, 0, 0, 1'b0);
        wait_valid("post_rst", 209, 1'b0);
        fill_exp(8, 64'd2);
        recv("post_rst", 8, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
